debug_sequencer: RTL and testbench
==================================

# debug_sequencer

UART-driven debug controller between the UART receiver/transmitter and the MIPS pipeline inside `top_modular`. It decodes host command bytes, loads instruction memory, gates the pipeline for continuous or step-by-step execution, and streams a register/latch dump back to the host after every halt or step. It is the only block that drives the pipeline enable, the processor soft reset and the instruction-memory write port.

## Interface
- `LEN`, 32: datapath word width.
- `ADDR_W`, 10: instruction-memory word-address width.
- `DUMP_WORDS`, 40: number of `LEN`-bit words sent per dump.
- `CLK100MHZ`  in  1  system clock; all logic on rising edge.
- `SWITCH_RESET`  in  1  reset, asynchronous and active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle pulse, `rx_data` valid.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts byte when `tx_valid && tx_ready`.
- `cpu_enable`  out  1  pipeline advances on cycles where high.
- `cpu_reset`  out  1  one-cycle processor soft reset (PC and latches to 0).
- `cpu_halt`  in  1  halt instruction reached the end of the pipeline.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  `ADDR_W`  word address.
- `imem_wdata`  out  `LEN`  word to write.
- `dump_sel`  out  clog2(`DUMP_WORDS`)  dump word index.
- `dump_data`  in  `LEN`  selected word, combinational from the CPU, valid the cycle `dump_sel` is stable.
- `state_dbg`  out  3  current state encoding (LED/ILA).

## Operation
- Commands: 0x01 START, 0x02 CONTINUOUS, 0x03 STEP_MODE, 0x05 REPROGRAM, 0x06 STEP. Any other byte is dropped.
- IDLE: 0x01 -> one-cycle `cpu_reset`, stay IDLE; 0x02 -> RUN; 0x03 -> STEP_WAIT; 0x05 -> PROGRAM (`imem_addr` cleared to 0, byte counter cleared).
- PROGRAM: bytes assembled MSB first; on the 4th byte write the word (`imem_we` one cycle), then increment `imem_addr`. Word 0xFFFFFFFF is written as well and ends programming -> IDLE. Past address 2^`ADDR_W`-1 writes are suppressed (no wrap); sentinel still terminates.
- RUN: `cpu_enable` high until `cpu_halt` is sampled high -> DUMP, then IDLE.
- STEP_WAIT: `cpu_enable` low. 0x06 -> exactly one enable cycle -> DUMP -> back to STEP_WAIT; if `cpu_halt` is high during or after that step, the DUMP returns to IDLE. 0x02 in STEP_WAIT -> RUN. Other bytes are dropped.
- DUMP: for i = 0..`DUMP_WORDS`-1, drive `dump_sel`=i, latch `dump_data` into a shift register, send 4 bytes MSB first via valid/ready.
- `rx_valid` in RUN or DUMP is dropped (no queue).

## Timing
- Reset values: `tx_valid`, `cpu_enable`, `cpu_reset`, `imem_we` = 0; `tx_data`, `imem_addr`, `imem_wdata`, `dump_sel` = 0; state IDLE.
- `SWITCH_RESET` asserted mid-operation aborts everything; no partial write or byte completes afterwards.
- All outputs are registered. Command byte on cycle N -> state/enable change visible on cycle N+1.
- `cpu_halt` high at cycle N -> `cpu_enable` low at N+1; dump latch of word 0 at N+1, first `tx_valid` at N+2.
- A 4th program byte at N -> `imem_we`/`imem_wdata`/`imem_addr` valid at N+1; address increments at N+2.
- `tx_data` must not change while `tx_valid && !tx_ready`. One byte per accepted handshake; with `tx_ready` held high, a dump takes exactly 4·`DUMP_WORDS` byte cycles plus 1 latch cycle per word.

## Structure
- Shared package `debug_pkg`: command byte constants, state enum (IDLE, PROGRAM, RUN, STEP_WAIT, STEP_EXEC, DUMP), and the sentinel 0xFFFFFFFF.
- One sub-module, `dump_serializer`: word latch plus 4-byte valid/ready shifter with a `done` pulse; the FSM, program assembler and enable gating remain at top level.

## Test plan
- Reset then 0x05, then bytes 00 00 00 2A, FF FF FF FF -> writes (addr 0, 0x0000002A) and (addr 1, 0xFFFFFFFF), then IDLE.
- 0x02 with `cpu_halt` raised 50 cycles later -> `cpu_enable` high exactly 50 cycles, then 160 bytes (`DUMP_WORDS`=40) with `dump_data`=i yield 00 00 00 i for each word.
- 0x03, then 0x06 three times -> three single-cycle `cpu_enable` pulses, each followed by a full dump; `state_dbg` returns to STEP_WAIT.
- `tx_ready` toggled randomly during a dump -> no byte lost or duplicated and `tx_data` stable while stalled.
- 0x01 in IDLE -> one-cycle `cpu_reset`; 0x06 and 0x44 in IDLE -> no output activity.
- `SWITCH_RESET` pulse mid-dump and mid-PROGRAM (after 2 bytes) -> all outputs 0 next edge; a fresh 0x05 restarts at addr 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug sequencer: host command bytes,
// controller states and the end-of-program sentinel word.
package debug_pkg;

    localparam logic [7:0] CMD_START      = 8'h01;
    localparam logic [7:0] CMD_CONTINUOUS = 8'h02;
    localparam logic [7:0] CMD_STEP_MODE  = 8'h03;
    localparam logic [7:0] CMD_REPROGRAM  = 8'h05;
    localparam logic [7:0] CMD_STEP       = 8'h06;

    localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROGRAM   = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STEP_EXEC = 3'd4,
        ST_DUMP      = 3'd5
    } state_e;

endpackage

// File: rtl/dump_serializer.sv
// Latches one dump word and sends it MSB byte first over a valid/ready
// handshake; done_o pulses in the cycle the last byte is accepted.
module dump_serializer #(
    parameter int LEN = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic [LEN-1:0] word_i,
    input  logic           tx_ready_i,
    output logic [7:0]     tx_data_o,
    output logic           tx_valid_o,
    output logic           done_o
);

    localparam int NB = LEN / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           accept, last_byte;

    assign accept    = valid_q && tx_ready_i;
    assign last_byte = (cnt_q == CW'(NB - 1));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i && !valid_q) begin
            shift_d = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            if (last_byte) begin
                valid_d = 1'b0;
            end else begin
                shift_d = shift_q << 8;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // The shifter only moves on an accepted byte, so tx_data holds while stalled.
    assign tx_data_o  = shift_q[LEN-1 -: 8];
    assign tx_valid_o = valid_q;
    assign done_o     = accept && last_byte;

endmodule

// File: rtl/debug_sequencer.sv
// UART debug controller: decodes host commands, loads instruction memory,
// gates the pipeline (run / single step) and streams a state dump after halts.
module debug_sequencer
    import debug_pkg::*;
#(
    parameter int  LEN        = 32,
    parameter int  ADDR_W     = 10,
    parameter int  DUMP_WORDS = 40,
    localparam int SEL_W      = $clog2(DUMP_WORDS)
) (
    input  logic              CLK100MHZ,
    input  logic              SWITCH_RESET,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              cpu_enable,
    output logic              cpu_reset,
    input  logic              cpu_halt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [LEN-1:0]    imem_wdata,
    output logic [SEL_W-1:0]  dump_sel,
    input  logic [LEN-1:0]    dump_data,
    output logic [2:0]        state_dbg
);

    localparam logic [LEN-1:0]    SENT     = LEN'(SENTINEL);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(DUMP_WORDS - 1);

    state_e            state_q, state_d, ret_q, ret_d;
    logic              enable_q, enable_d, soft_rst_q, soft_rst_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [LEN-9:0]    asm_q, asm_d;
    logic [LEN-1:0]    wdata_q, wdata_d;
    logic              we_q, we_d, inc_q, inc_d, full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic [LEN-1:0]    asm_word;
    logic              word_done, dump_last, ser_load, ser_valid, ser_done;

    assign asm_word  = {asm_q, rx_data};
    assign word_done = rx_valid && (state_q == ST_PROGRAM) && (byte_cnt_q == 2'd3);
    assign dump_last = ser_done && (sel_q == SEL_LAST);
    assign ser_load  = (state_q == ST_DUMP) && !ser_valid;

    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_CONTINUOUS: state_d = ST_RUN;
                        CMD_STEP_MODE:  state_d = ST_STEP_WAIT;
                        CMD_REPROGRAM:  state_d = ST_PROGRAM;
                        default:        state_d = ST_IDLE;
                    endcase
                end
            end
            ST_PROGRAM: begin
                if (word_done && (asm_word == SENT)) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_d = ST_DUMP;
                    ret_d   = ST_IDLE;
                end
            end
            ST_STEP_WAIT: begin
                if (rx_valid && (rx_data == CMD_STEP)) state_d = ST_STEP_EXEC;
                else if (rx_valid && (rx_data == CMD_CONTINUOUS)) state_d = ST_RUN;
            end
            ST_STEP_EXEC: begin
                state_d = ST_DUMP;
                ret_d   = cpu_halt ? ST_IDLE : ST_STEP_WAIT;
            end
            ST_DUMP: begin
                // A halt seen at any point of a step's dump ends stepping.
                if (cpu_halt) ret_d = ST_IDLE;
                if (dump_last) state_d = ret_d;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enable_d   = (state_d == ST_RUN) || (state_d == ST_STEP_EXEC);
        soft_rst_d = (state_q == ST_IDLE) && rx_valid && (rx_data == CMD_START);
    end

    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) begin
            enable_q   <= 1'b0;
            soft_rst_q <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            soft_rst_q <= soft_rst_d;
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        full_d     = full_q;
        we_d       = 1'b0;
        inc_d      = 1'b0;
        sel_d      = sel_q;

        // The address advances the cycle after a write; at the top it saturates and marks full.
        if (inc_q) begin
            if (addr_q == ADDR_MAX) full_d = 1'b1;
            else                    addr_d = addr_q + ADDR_W'(1);
        end
        if ((state_q == ST_IDLE) && rx_valid && (rx_data == CMD_REPROGRAM)) begin
            addr_d     = '0;
            full_d     = 1'b0;
            byte_cnt_d = '0;
            asm_d      = '0;
        end
        if ((state_q == ST_PROGRAM) && rx_valid) begin
            asm_d      = asm_word[LEN-9:0];
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (word_done) begin
                wdata_d = asm_word;
                we_d    = !full_q;
                inc_d   = 1'b1;
            end
        end
        if (ser_done) sel_d = dump_last ? '0 : sel_q + SEL_W'(1);
    end

    always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
        if (SWITCH_RESET) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            full_q     <= 1'b0;
            we_q       <= 1'b0;
            inc_q      <= 1'b0;
            sel_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            we_q       <= we_d;
            inc_q      <= inc_d;
            sel_q      <= sel_d;
        end
    end

    dump_serializer #(
        .LEN (LEN)
    ) u_dump_serializer (
        .clk_i      (CLK100MHZ),
        .rst_i      (SWITCH_RESET),
        .load_i     (ser_load),
        .word_i     (dump_data),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (ser_valid),
        .done_o     (ser_done)
    );

    assign tx_valid   = ser_valid;
    assign cpu_enable = enable_q;
    assign cpu_reset  = soft_rst_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign dump_sel   = sel_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Self-checking bench for debug_sequencer: byte-level host stimulus, a
// behavioural model of programming writes and dump byte streams.
module tb_debug_sequencer;

    localparam int LEN        = 32;
    localparam int ADDR_W     = 10;
    localparam int DUMP_WORDS = 40;
    localparam int SEL_W      = 6;

    localparam logic [2:0] S_IDLE = 3'd0, S_PROG = 3'd1, S_RUN = 3'd2,
                           S_SWAIT = 3'd3, S_SEXEC = 3'd4, S_DUMP = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN-1:0]    data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              cpu_enable, cpu_reset;
    logic              cpu_halt = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [LEN-1:0]    imem_wdata;
    logic [SEL_W-1:0]  dump_sel;
    logic [LEN-1:0]    dump_data;
    logic [2:0]        state_dbg;
    logic [62:0]       all_out;

    logic [LEN-1:0] dump_mem [DUMP_WORDS];
    logic [LEN-1:0] prog_words[$];
    logic [7:0]     got[$];
    wr_t            writes[$];

    int tests = 0, failed = 0;
    int en_cycles = 0, rst_cycles = 0, dump_cycles = 0, activity = 0;

    always #5 clk = ~clk;

    assign dump_data = (dump_sel < SEL_W'(DUMP_WORDS)) ? dump_mem[dump_sel] : '0;
    assign all_out   = {tx_valid, cpu_enable, cpu_reset, imem_we, tx_data,
                        imem_addr, imem_wdata, dump_sel, state_dbg};

    debug_sequencer #(
        .LEN        (LEN),
        .ADDR_W     (ADDR_W),
        .DUMP_WORDS (DUMP_WORDS)
    ) dut (
        .CLK100MHZ    (clk),
        .SWITCH_RESET (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .cpu_enable   (cpu_enable),
        .cpu_reset    (cpu_reset),
        .cpu_halt     (cpu_halt),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .dump_sel     (dump_sel),
        .dump_data    (dump_data),
        .state_dbg    (state_dbg)
    );

    // Bus monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (imem_we) writes.push_back({imem_addr, imem_wdata});
        if (cpu_enable) en_cycles <= en_cycles + 1;
        if (cpu_reset) rst_cycles <= rst_cycles + 1;
        if (state_dbg == S_DUMP) dump_cycles <= dump_cycles + 1;
        if (tx_valid || imem_we || cpu_enable || cpu_reset) activity <= activity + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic fill_dump(input bit random_fill);
        for (int i = 0; i < DUMP_WORDS; i++)
            dump_mem[i] = random_fill ? LEN'($urandom) : LEN'(i);
    endtask

    task automatic wait_bytes(input int n, input int budget, input bit rnd);
        int         c = 0;
        logic       stall = 1'b0;
        logic [7:0] held = 8'h00;
        while (got.size() < n && c < budget) begin
            if (stall) begin
                tests++;
                if (tx_valid !== 1'b1 || tx_data !== held) begin
                    failed++;
                    $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, held);
                end
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall    = tx_valid && !tx_ready;
            held     = tx_data;
            step();
            c++;
        end
        tx_ready = 1'b1;
        tests++;
        if (got.size() < n) begin
            failed++;
            $display("FAIL wait_bytes: %0d bytes within budget, required %0d", got.size(), n);
        end
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int budget);
        int c = 0;
        while (state_dbg !== st && c < budget) begin
            step();
            c++;
        end
        tests++;
        if (state_dbg !== st) begin
            failed++;
            $display("FAIL %s: state_dbg=%0d, required %0d", name, state_dbg, st);
        end
    endtask

    // Expected stream: every dump word, most significant byte first.
    task automatic check_dump(input string name);
        logic [7:0] exp[$];
        int         bad = -1;
        for (int i = 0; i < DUMP_WORDS; i++)
            for (int b = LEN / 8 - 1; b >= 0; b--)
                exp.push_back(dump_mem[i][8*b +: 8]);
        tests++;
        if (got.size() != exp.size()) begin
            failed++;
            $display("FAIL %s: %0d bytes received, required %0d", name, got.size(), exp.size());
        end else begin
            foreach (exp[k]) if (bad < 0 && got[k] !== exp[k]) bad = k;
            if (bad >= 0) begin
                failed++;
                $display("FAIL %s: byte %0d is %02h, required %02h", name, bad, got[bad], exp[bad]);
            end
        end
        got.delete();
    endtask

    task automatic run_program(input int max_gap);
        writes.delete();
        send_byte(8'h05);
        foreach (prog_words[k]) begin
            for (int b = 3; b >= 0; b--) begin
                send_byte(prog_words[k][8*b +: 8]);
                repeat ($urandom_range(0, max_gap)) step();
            end
        end
        repeat (3) step();
    endtask

    // Word k lands at address k; anything beyond the last address is not written.
    task automatic check_writes(input string name);
        wr_t exp[$];
        int  bad = -1;
        foreach (prog_words[k])
            if (k < (1 << ADDR_W)) exp.push_back({ADDR_W'(k), prog_words[k]});
        tests++;
        if (writes.size() != exp.size()) begin
            failed++;
            $display("FAIL %s: %0d writes seen, required %0d", name, writes.size(), exp.size());
        end else begin
            foreach (exp[k]) if (bad < 0 && writes[k] !== exp[k]) bad = k;
            if (bad >= 0) begin
                failed++;
                $display("FAIL %s: write %0d is addr %0d data %08h, required addr %0d data %08h",
                         name, bad, writes[bad].addr, writes[bad].data, exp[bad].addr, exp[bad].data);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic required);
        tests++;
        if (actual !== required) begin
            failed++;
            $display("FAIL %s: got %0b, required %0b", name, actual, required);
        end
    endtask

    task automatic check_val(input string name, input logic [62:0] actual, input logic [62:0] required);
        tests++;
        if (actual !== required) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        check_val("reset_outputs", all_out, '0);
        rst = 1'b0;
        step();
        check_val("post_reset_outputs", all_out, '0);
    endtask

    task automatic test_program();
        writes.delete();
        send_byte(8'h05);
        check_val("prog_state", 63'(state_dbg), 63'(S_PROG));
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h2A);
        check_val("prog_write_cycle", {imem_we, imem_addr, imem_wdata},
                  {1'b1, ADDR_W'(0), 32'h0000_002A});
        step();
        check_val("prog_addr_inc", {imem_we, imem_addr}, {1'b0, ADDR_W'(1)});
        repeat (4) send_byte(8'hFF);
        check_val("prog_sentinel_idle", 63'(state_dbg), 63'(S_IDLE));
        prog_words = '{32'h0000_002A, 32'hFFFF_FFFF};
        step();
        check_writes("prog_directed");

        prog_words.delete();
        for (int k = 0; k < 3; k++) begin
            logic [LEN-1:0] w = LEN'($urandom);
            if (w == '1) w = '0;
            prog_words.push_back(w);
        end
        prog_words.push_back('1);
        run_program(2);
        check_writes("prog_random");
        check_val("prog_random_idle", 63'(state_dbg), 63'(S_IDLE));
    endtask

    task automatic test_program_overflow();
        prog_words.delete();
        for (int k = 0; k < (1 << ADDR_W) + 1; k++) begin
            logic [LEN-1:0] w = LEN'($urandom);
            if (w == '1) w = '0;
            prog_words.push_back(w);
        end
        prog_words.push_back('1);
        run_program(0);
        check_writes("prog_overflow");
        check_val("prog_overflow_idle", 63'(state_dbg), 63'(S_IDLE));
    endtask

    task automatic test_idle_cmds();
        int r0, a0;
        r0 = rst_cycles;
        send_byte(8'h01);
        check_bit("start_cpu_reset_high", cpu_reset, 1'b1);
        step();
        check_bit("start_cpu_reset_low", cpu_reset, 1'b0);
        check_val("start_reset_cycles", 63'(rst_cycles - r0), 63'd1);
        got.delete();
        a0 = activity;
        send_byte(8'h06);
        send_byte(8'h44);
        repeat (5) step();
        check_val("idle_junk_activity", 63'(activity - a0), 63'd0);
        check_val("idle_junk_state", 63'(state_dbg), 63'(S_IDLE));
    endtask

    task automatic test_run_dump();
        int e0, d0;
        fill_dump(1'b0);
        got.delete();
        e0 = en_cycles;
        d0 = dump_cycles;
        send_byte(8'h02);
        check_val("run_enter", {state_dbg, cpu_enable}, {S_RUN, 1'b1});
        repeat (49) step();
        cpu_halt = 1'b1;
        step();
        check_val("run_halt_response", {cpu_enable, tx_valid, state_dbg}, {1'b0, 1'b0, S_DUMP});
        step();
        check_val("dump_first_byte", {tx_valid, tx_data}, {1'b1, 8'h00});
        wait_bytes(4 * DUMP_WORDS, 2000, 1'b0);
        wait_state("run_dump_idle", S_IDLE, 50);
        check_dump("run_dump_bytes");
        check_val("run_enable_cycles", 63'(en_cycles - e0), 63'd50);
        check_val("dump_duration", 63'(dump_cycles - d0), 63'(5 * DUMP_WORDS));
        cpu_halt = 1'b0;
    endtask

    task automatic test_step();
        int e0;
        send_byte(8'h03);
        check_val("step_mode_enter", {state_dbg, cpu_enable}, {S_SWAIT, 1'b0});
        for (int s = 0; s < 3; s++) begin
            fill_dump(1'b1);
            got.delete();
            e0 = en_cycles;
            send_byte(8'h06);
            check_val("step_pulse_on", {state_dbg, cpu_enable}, {S_SEXEC, 1'b1});
            step();
            check_val("step_pulse_off", {state_dbg, cpu_enable}, {S_DUMP, 1'b0});
            send_byte(8'h02);
            wait_bytes(4 * DUMP_WORDS, 2000, 1'b0);
            wait_state("step_return_wait", S_SWAIT, 20);
            check_dump("step_dump_bytes");
            check_val("step_enable_cycles", 63'(en_cycles - e0), 63'd1);
        end
        fill_dump(1'b1);
        got.delete();
        send_byte(8'h06);
        step();
        cpu_halt = 1'b1;
        wait_bytes(4 * DUMP_WORDS, 2000, 1'b0);
        wait_state("step_halt_idle", S_IDLE, 20);
        check_dump("step_halt_dump");
        cpu_halt = 1'b0;
    endtask

    task automatic test_random_ready();
        fill_dump(1'b1);
        got.delete();
        cpu_halt = 1'b1;
        send_byte(8'h02);
        wait_bytes(4 * DUMP_WORDS, 6000, 1'b1);
        wait_state("rand_ready_idle", S_IDLE, 50);
        check_dump("rand_ready_bytes");
        cpu_halt = 1'b0;
    endtask

    task automatic test_reset_abort();
        fill_dump(1'b1);
        got.delete();
        cpu_halt = 1'b1;
        send_byte(8'h02);
        wait_bytes(10, 500, 1'b0);
        rst = 1'b1;
        step();
        check_val("abort_dump_outputs", all_out, '0);
        cpu_halt = 1'b0;
        step();
        rst = 1'b0;
        got.delete();
        repeat (30) step();
        check_val("abort_dump_silent", {63'(got.size())}, 63'd0);
        check_val("abort_dump_state", 63'(state_dbg), 63'(S_IDLE));

        writes.delete();
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        step();
        check_val("abort_prog_outputs", all_out, '0);
        rst = 1'b0;
        step();
        check_val("abort_prog_no_write", 63'(writes.size()), 63'd0);
        prog_words = '{LEN'($urandom) & 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        run_program(1);
        check_writes("abort_prog_restart");
    endtask

    initial begin
        test_reset();
        test_program();
        test_idle_cmds();
        test_run_dump();
        test_step();
        test_random_ready();
        test_reset_abort();
        test_program_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
